// File: rtl/mb_shift_seq.sv
// Multi-byte one-bit shift sequencer driving the 8-bit ALU shift unit byte by byte.
// Optional MULTI_BIT_EN: adds shamt input, repeating the full pass shamt+1 times.
module mb_shift_seq #(
   parameter int ADDR_W    = 8,
   parameter int MAX_BYTES = 8,
   localparam int NB_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              dir,
   input  logic              fill,
   input  logic [ADDR_W-1:0] base,
   input  logic [NB_W-1:0]   nbytes,
`ifdef MULTI_BIT_EN
   input  logic [2:0]        shamt,
`endif
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              carry_o,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   output logic [2:0]        alu_cmd,
   output logic [2:0]        typeselect,
   output logic [7:0]        alu_a,
   output logic              alu_sc_in,
   input  logic [7:0]        alu_rslt,
   input  logic              alu_sc_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            state, state_nx;
   logic              dir_r, fill_r, err_r, carry_r, carry_o_r;
   logic [ADDR_W-1:0] base_r, cur_addr;
   logic [NB_W-1:0]   nb_r, idx, rem, off;
   logic [7:0]        rslt_r;
   logic              first_byte, last_byte, last_pass, bad_len;

`ifdef MULTI_BIT_EN
   logic [2:0] shamt_r, pass_r;
   assign last_pass = (pass_r == shamt_r);
`else
   assign last_pass = 1'b1;
`endif

   assign bad_len    = (nbytes > NB_W'(MAX_BYTES));
   assign first_byte = (idx == '0);
   assign last_byte  = (idx == nb_r - NB_W'(1));
   // Right shifts walk from the MSB byte down, so the offset counts back from n-1.
   assign rem        = nb_r - idx - NB_W'(1);
   assign off        = dir_r ? rem : idx;
   assign cur_addr   = base_r + ADDR_W'(off);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         dir_r     <= 1'b0;
         fill_r    <= 1'b0;
         err_r     <= 1'b0;
         carry_r   <= 1'b0;
         carry_o_r <= 1'b0;
         base_r    <= '0;
         nb_r      <= '0;
         idx       <= '0;
         rslt_r    <= '0;
`ifdef MULTI_BIT_EN
         shamt_r   <= '0;
         pass_r    <= '0;
`endif
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: if (start) begin
               dir_r     <= dir;
               fill_r    <= fill;
               base_r    <= base;
               nb_r      <= nbytes;
               idx       <= '0;
               err_r     <= bad_len;
               carry_o_r <= 1'b0;
`ifdef MULTI_BIT_EN
               shamt_r   <= shamt;
               pass_r    <= '0;
`endif
            end
            S_EXEC: begin
               rslt_r  <= alu_rslt;
               carry_r <= alu_sc_o;
            end
            S_WRITE: begin
               if (last_byte) begin
                  idx <= '0;
                  if (last_pass) carry_o_r <= carry_r;
`ifdef MULTI_BIT_EN
                  else pass_r <= pass_r + 3'd1;
`endif
               end else begin
                  idx <= idx + NB_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx   = state;
      busy       = 1'b0;
      done       = 1'b0;
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      alu_cmd    = 3'b111;
      typeselect = '0;
      alu_a      = '0;
      alu_sc_in  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = (nbytes == '0 || bad_len) ? S_DONE : S_READ;
         end
         S_READ: begin
            busy     = 1'b1;
            mem_addr = cur_addr;
            state_nx = S_EXEC;
         end
         S_EXEC: begin
            busy       = 1'b1;
            alu_cmd    = 3'b001;
            alu_a      = mem_rdata;
            typeselect = first_byte ? {1'b0, dir_r, fill_r} : {2'b10, dir_r};
            alu_sc_in  = first_byte ? 1'b0 : carry_r;
            state_nx   = S_WRITE;
         end
         S_WRITE: begin
            busy      = 1'b1;
            mem_addr  = cur_addr;
            mem_we    = 1'b1;
            mem_wdata = rslt_r;
            state_nx  = (last_byte && last_pass) ? S_DONE : S_READ;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign err     = done & err_r;
   assign carry_o = carry_o_r;

endmodule
